// File: rtl/result_pkg.sv
// Shared types for the binary-to-BCD result converter: FSM states, BCD digit and blank code.
package result_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BLANK_CODE = 4'hF;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to any BCD digit of 5 or more before the shift.
module bcd_digit_adj
  import result_pkg::*;
(
  input  bcd_digit_t digit_i,
  output bcd_digit_t digit_o
);

  always_comb begin
    digit_o = digit_i;
    if (digit_i >= 4'd5) begin
      digit_o = digit_i + 4'd3;
    end
  end

endmodule

// File: rtl/result_bcd.sv
// Sequential double-dabble converter from the ALU result to packed BCD for the display.
// Optional feature: define RESULT_BCD_BLANK_EN to blank leading zero digits with 4'hF.
module result_bcd
  import result_pkg::*;
#(
  parameter int unsigned WIDTH  = 12,
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  if (64'd10 ** DIGITS < (64'd1 << WIDTH)) begin : g_range_err
    $error("result_bcd: DIGITS cannot represent every WIDTH-bit value");
  end

  state_t              state_q;
  logic [WIDTH-1:0]    bin_q, bin_d;
  logic [4*DIGITS-1:0] acc_q, acc_d;
  logic [4*DIGITS-1:0] adj;
  logic [4*DIGITS-1:0] disp_d;
  logic [4*DIGITS-1:0] out_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                in_ready_q;
  logic                out_valid_q;

  for (genvar g = 0; g < int'(DIGITS); g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (acc_q[4*g +: 4]),
      .digit_o (adj[4*g +: 4])
    );
  end

  assign {acc_d, bin_d} = {adj, bin_q} << 1;

  // Display value computed from the final iteration so it is loaded on DONE entry only.
  always_comb begin
    disp_d = acc_d;
`ifdef RESULT_BCD_BLANK_EN
    begin
      logic lead;
      lead = 1'b1;
      for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
        if (lead && disp_d[4*i +: 4] == 4'd0) begin
          disp_d[4*i +: 4] = BLANK_CODE;
        end else begin
          lead = 1'b0;
        end
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bin_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            bin_q      <= in_data;
            acc_q      <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          acc_q <= acc_d;
          bin_q <= bin_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            out_q       <= disp_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_bcd   = out_q;

endmodule

// File: tb/tb_result_bcd.sv
// Directed bench for result_bcd: vector table plus hold, back-to-back and reset-abort sequences.
module tb_result_bcd;

`ifdef RESULT_BCD_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_bcd;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [11:0] data;
    logic [15:0] raw;
    logic [15:0] blk;
  } vec_t;

  vec_t vecs[10];

  result_bcd #(.WIDTH(12), .DIGITS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bcd   (out_bcd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] pick(input logic [15:0] raw, input logic [15:0] blk);
    return BLANK ? blk : raw;
  endfunction

  // Accept one value, measure latency, check SHIFT-time invariants, then drain with out_ready.
  task automatic run_conv(input logic [11:0] d, input logic [15:0] exp, input string nm);
    int k;
    int n;
    logic ok;
    logic [15:0] prev;
    @(negedge clk);
    in_data  = d;
    in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk({nm, ":ready"}, 32'(in_ready), 32'd1);
    prev = out_bcd;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n  = 0;
    ok = 1'b1;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      n++;
      #1;
      if (!out_valid && (out_bcd !== prev || in_ready !== 1'b0)) ok = 1'b0;
    end
    chk({nm, ":latency"}, 32'(n), 32'd12);
    chk({nm, ":shift_quiet"}, 32'(ok), 32'd1);
    chk({nm, ":bcd"}, 32'(out_bcd), 32'(exp));
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({nm, ":drain_valid"}, 32'(out_valid), 32'd0);
    chk({nm, ":drain_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int n;
    logic ok;

    vecs[0] = '{12'd4095, 16'h4095, 16'h4095};
    vecs[1] = '{12'd0,    16'h0000, 16'hFFF0};
    vecs[2] = '{12'd1234, 16'h1234, 16'h1234};
    vecs[3] = '{12'd15,   16'h0015, 16'hFF15};
    vecs[4] = '{12'd7,    16'h0007, 16'hFFF7};
    vecs[5] = '{12'd999,  16'h0999, 16'hF999};
    vecs[6] = '{12'd100,  16'h0100, 16'hF100};
    vecs[7] = '{12'd9,    16'h0009, 16'hFFF9};
    vecs[8] = '{12'd4000, 16'h4000, 16'h4000};
    vecs[9] = '{12'd10,   16'h0010, 16'hFF10};

    #12;
    chk("reset:out_valid", 32'(out_valid), 32'd0);
    chk("reset:in_ready", 32'(in_ready), 32'd1);
    chk("reset:out_bcd", 32'(out_bcd), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_conv(vecs[i].data, pick(vecs[i].raw, vecs[i].blk), $sformatf("vec%0d", i));
    end

    // Stall in DONE with a competing in_valid; it must wait for the out_ready edge.
    run_conv(12'd1234, 16'h1234, "pre_hold");
    @(negedge clk);
    in_data = 12'd1234; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin @(posedge clk); n++; #1; end
    chk("hold:latency", 32'(n), 32'd12);
    in_valid = 1'b1; in_data = 12'd555;
    ok = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (out_bcd !== 16'h1234 || out_valid !== 1'b1 || in_ready !== 1'b0) ok = 1'b0;
    end
    chk("hold:stable", 32'(ok), 32'd1);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    chk("hold:idle_ready", 32'(in_ready), 32'd1);
    chk("hold:idle_valid", 32'(out_valid), 32'd0);
    n = 0;
    while (!out_valid && n < 40) begin @(posedge clk); n++; #1; end
    in_valid = 1'b0;
    chk("hold:next_latency", 32'(n), 32'd13);
    chk("hold:next_bcd", 32'(out_bcd), 32'(pick(16'h0555, 16'hF555)));
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;

    // Back-to-back with in_valid and out_ready held high.
    @(negedge clk);
    in_data = 12'd15; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (!out_valid && n < 40) begin @(posedge clk); n++; #1; end
    chk("b2b:lat1", 32'(n), 32'd12);
    chk("b2b:bcd1", 32'(out_bcd), 32'(pick(16'h0015, 16'hFF15)));
    in_data = 12'd7;
    @(posedge clk); #1;
    chk("b2b:pulse", 32'(out_valid), 32'd0);
    chk("b2b:idle", 32'(in_ready), 32'd1);
    n = 1;
    while (!out_valid && n < 40) begin @(posedge clk); n++; #1; end
    chk("b2b:gap", 32'(n), 32'd14);
    chk("b2b:bcd2", 32'(out_bcd), 32'(pick(16'h0007, 16'hFFF7)));
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("b2b:drained", 32'(in_ready), 32'd1);

    // Reset in the middle of converting 999.
    @(negedge clk);
    in_data = 12'd999; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1; rst = 1'b1; #1;
    chk("rst:out_valid", 32'(out_valid), 32'd0);
    chk("rst:out_bcd", 32'(out_bcd), 32'd0);
    chk("rst:in_ready", 32'(in_ready), 32'd1);
    @(negedge clk); rst = 1'b0;
    ok = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || out_bcd !== 16'h0) ok = 1'b0;
    end
    chk("rst:aborted", 32'(ok), 32'd1);
    run_conv(12'd999, pick(16'h0999, 16'hF999), "rst:redo");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
